pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter: XREG_ADDRWIDTH, 5, register-address width.
REQ-002 SHALL have parameter: MEM_TIMEOUT, 255, max MEM_WAIT cycles before abort.
REQ-003 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: id_rs1_addr/id_rs2_addr  in  XREG_ADDRWIDTH each  ID-stage source regs; id_rs1_use/id_rs2_use  in  1 each  source actually read.
REQ-006 SHALL have ports: ex_is_load  in  1  EX holds a load; ex_rd_en  in  1  and ex_rd_addr  in  XREG_ADDRWIDTH  EX destination.
REQ-007 SHALL have port: ex_branch_taken  in  1  EX redirect (taken branch/jump).
REQ-008 SHALL have ports: mdu_start  in  1  EX holds a mul/div; mdu_done  in  1  result valid.
REQ-009 SHALL have ports: dmem_req  in  1  MEM-stage access pending; dmem_ack  in  1  access complete.
REQ-010 SHALL have outputs, 1 bit each: pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble (to ID/EX load_hazerd), id_ex_flush (to ID/EX flush_flag), ex_mem_hold, ex_mem_bubble, mem_wb_bubble.
REQ-011 SHALL have outputs: state  out  2  current FSM state; stall_cnt  out  32  hold cycles; flush_cnt  out  16  redirects; mem_err  out  1  sticky timeout flag.

Function
REQ-012 SHALL implement FSM states RUN=0, MDU_WAIT=1, MEM_WAIT=2; encoding 3 illegal, next state RUN.
REQ-013 Control outputs SHALL be combinational from state and current inputs (zero-cycle latency); counters, state, mem_err registered.
REQ-014 Load-use hazard = ex_is_load & ex_rd_en & ex_rd_addr!=0 & ((id_rs1_use & rs1==rd) | (id_rs2_use & rs2==rd)).
REQ-015 Priority in RUN, highest first: memory stall, MDU stall, branch flush, load-use.
REQ-016 RUN, dmem_req & !dmem_ack: assert pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_bubble; next MEM_WAIT.
REQ-017 MEM_WAIT: same holds as REQ-016 while !dmem_ack; dmem_ack releases all holds that cycle, next RUN.
REQ-018 MEM_WAIT wait counter SHALL count cycles in state; reaching MEM_TIMEOUT SHALL set mem_err, release holds that cycle, return to RUN; counter clears on entry.
REQ-019 RUN, mdu_start & !mdu_done (no memory stall): assert pc_hold, if_id_hold, id_ex_hold, ex_mem_bubble; next MDU_WAIT. mdu_start & mdu_done same cycle: no stall.
REQ-020 MDU_WAIT: holds of REQ-019 while !mdu_done; mdu_done releases them that cycle, next RUN.
REQ-021 RUN, ex_branch_taken (no memory/MDU stall): if_id_flush=1, id_ex_flush=1 for exactly that cycle; load-use suppressed; flush_cnt +1 (wraps at 16'hFFFF->0).
REQ-022 RUN, load-use only: pc_hold=1, if_id_hold=1, id_ex_bubble=1 for one cycle; state stays RUN.
REQ-023 ex_branch_taken during MEM_WAIT/MDU_WAIT SHALL be ignored until RUN (EX is held, input stays asserted).
REQ-024 stall_cnt SHALL increment every cycle pc_hold=1, saturating at 32'hFFFFFFFF.
REQ-025 mem_err SHALL clear only on reset.

Reset
REQ-026 rst=1 SHALL immediately force state=RUN, stall_cnt=0, flush_cnt=0, mem_err=0, wait counter=0; control outputs then follow RUN decoding of inputs.
REQ-027 Reset mid-MEM_WAIT/MDU_WAIT SHALL abandon the wait with no pending flag retained.

Structure
REQ-028 State encodings and counter widths SHALL live in the shared config/package file alongside existing global defines.
REQ-029 One sub-module, pipe_perf_cnt (parameterized saturating/wrapping counter), SHALL implement stall_cnt and flush_cnt.

Verification
REQ-030 ex_is_load=1, ex_rd_addr=5, id_rs1_addr=5, id_rs1_use=1 -> one cycle pc_hold=if_id_hold=id_ex_bubble=1; rd=0 -> no stall.
REQ-031 ex_branch_taken=1 with same load-use -> if_id_flush=id_ex_flush=1, id_ex_bubble=0, flush_cnt 0->1.
REQ-032 mdu_start=1, mdu_done after 4 cycles -> state MDU_WAIT 4 cycles, holds released on done cycle, stall_cnt=5.
REQ-033 dmem_req=1 with mdu_start=1, ack after 3 cycles -> MEM_WAIT first, then MDU_WAIT; ex_mem_hold only in MEM_WAIT.
REQ-034 MEM_TIMEOUT=8, dmem_ack never -> mem_err=1 after 8 cycles, state RUN, mem_err persists until rst.
REQ-035 rst asserted mid-MDU_WAIT between clock edges -> state=0, counters=0 without waiting for clk.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared configuration for the pipeline hazard controller: FSM encoding
// and performance-counter widths used by the controller and its counters.
package pipe_hazard_ctrl_pkg;

  localparam int XREG_ADDRWIDTH_DEF = 5;
  localparam int MEM_TIMEOUT_DEF    = 255;

  localparam int STATE_W     = 2;
  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 16;

  // Encoding 2'b11 is unused; the controller treats it as illegal and
  // returns to RUN on the next clock.
  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Event counter used for pipeline statistics. SATURATE=1 sticks at all-ones,
// SATURATE=0 wraps back to zero.
module pipe_perf_cnt #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count one event per clock when inc is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      if (SATURATE && (&count)) begin
        count <= count;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: decodes load-use, branch redirect, multi-cycle
// MDU and memory stalls into hold/bubble/flush controls, with a memory-wait
// timeout and stall/flush statistics counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XREG_ADDRWIDTH = XREG_ADDRWIDTH_DEF,
  parameter int MEM_TIMEOUT    = MEM_TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XREG_ADDRWIDTH-1:0] id_rs1_addr,
  input  logic [XREG_ADDRWIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_use,
  input  logic                      id_rs2_use,
  input  logic                      ex_is_load,
  input  logic                      ex_rd_en,
  input  logic [XREG_ADDRWIDTH-1:0] ex_rd_addr,
  input  logic                      ex_branch_taken,
  input  logic                      mdu_start,
  input  logic                      mdu_done,
  input  logic                      dmem_req,
  input  logic                      dmem_ack,
  output logic                      pc_hold,
  output logic                      if_id_hold,
  output logic                      if_id_flush,
  output logic                      id_ex_hold,
  output logic                      id_ex_bubble,
  output logic                      id_ex_flush,
  output logic                      ex_mem_hold,
  output logic                      ex_mem_bubble,
  output logic                      mem_wb_bubble,
  output logic [STATE_W-1:0]        state,
  output logic [STALL_CNT_W-1:0]    stall_cnt,
  output logic [FLUSH_CNT_W-1:0]    flush_cnt,
  output logic                      mem_err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t         state_q;
  hz_state_t         state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_inc;
  logic              load_use;
  logic              mem_stall;
  logic              mdu_stall;
  logic              mem_timeout;

  assign state        = state_q;
  assign wait_cnt_inc = wait_cnt + WAIT_W'(1);
  assign mem_stall    = dmem_req & ~dmem_ack;
  assign mdu_stall    = mdu_start & ~mdu_done;
  assign load_use     = ex_is_load & ex_rd_en & (ex_rd_addr != '0) &
                        ((id_rs1_use & (id_rs1_addr == ex_rd_addr)) |
                         (id_rs2_use & (id_rs2_addr == ex_rd_addr)));

  // State register; reset abandons any wait in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Cycles spent in MEM_WAIT; zero whenever the FSM is elsewhere, so it is
  // already clear on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_q == MEM_WAIT) begin
      wait_cnt <= wait_cnt_inc;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky memory timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if (mem_timeout) begin
      mem_err <= 1'b1;
    end
  end

  // Next-state and zero-latency control decode; memory beats MDU beats
  // branch beats load-use while running, and waits ignore redirects.
  always_comb begin
    state_nxt     = state_q;
    mem_timeout   = 1'b0;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_hold   = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          pc_hold       = 1'b1;
          if_id_hold    = 1'b1;
          id_ex_hold    = 1'b1;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
          state_nxt     = MEM_WAIT;
        end else if (mdu_stall) begin
          pc_hold       = 1'b1;
          if_id_hold    = 1'b1;
          id_ex_hold    = 1'b1;
          ex_mem_bubble = 1'b1;
          state_nxt     = MDU_WAIT;
        end else if (ex_branch_taken) begin
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
        end else if (load_use) begin
          pc_hold       = 1'b1;
          if_id_hold    = 1'b1;
          id_ex_bubble  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_nxt     = RUN;
        end else if (wait_cnt_inc == WAIT_W'(MEM_TIMEOUT)) begin
          mem_timeout   = 1'b1;
          state_nxt     = RUN;
        end else begin
          pc_hold       = 1'b1;
          if_id_hold    = 1'b1;
          id_ex_hold    = 1'b1;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          state_nxt     = RUN;
        end else begin
          pc_hold       = 1'b1;
          if_id_hold    = 1'b1;
          id_ex_hold    = 1'b1;
          ex_mem_bubble = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  pipe_perf_cnt #(
    .WIDTH    (STALL_CNT_W),
    .SATURATE (1'b1)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_hold),
    .count (stall_cnt)
  );

  pipe_perf_cnt #(
    .WIDTH    (FLUSH_CNT_W),
    .SATURATE (1'b0)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (id_ex_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with a short memory timeout.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;

  // Control bundle order: pc_hold, if_id_hold, if_id_flush, id_ex_hold,
  // id_ex_bubble, id_ex_flush, ex_mem_hold, ex_mem_bubble, mem_wb_bubble.
  localparam logic [8:0] C_NONE    = 9'b000_000_000;
  localparam logic [8:0] C_LOADUSE = 9'b110_010_000;
  localparam logic [8:0] C_FLUSH   = 9'b001_001_000;
  localparam logic [8:0] C_MEM     = 9'b110_100_101;
  localparam logic [8:0] C_MDU     = 9'b110_100_010;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic          id_rs1_use, id_rs2_use, ex_is_load, ex_rd_en, ex_branch_taken;
  logic          mdu_start, mdu_done, dmem_req, dmem_ack;
  logic          pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble;
  logic          id_ex_flush, ex_mem_hold, ex_mem_bubble, mem_wb_bubble;
  logic [1:0]    state;
  logic [31:0]   stall_cnt;
  logic [15:0]   flush_cnt;
  logic          mem_err;
  logic [8:0]    ctrl;

  int            vectors = 0;
  int            miscompares = 0;
  logic [31:0]   exp_stall = '0;
  logic [15:0]   exp_flush = '0;

  assign ctrl = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble,
                 id_ex_flush, ex_mem_hold, ex_mem_bubble, mem_wb_bubble};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XREG_ADDRWIDTH(AW), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .ex_is_load(ex_is_load), .ex_rd_en(ex_rd_en), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken),
    .mdu_start(mdu_start), .mdu_done(mdu_done),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_bubble(id_ex_bubble), .id_ex_flush(id_ex_flush),
    .ex_mem_hold(ex_mem_hold), .ex_mem_bubble(ex_mem_bubble), .mem_wb_bubble(mem_wb_bubble),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
  );

  task automatic drive_idle();
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    id_rs1_use = 1'b0; id_rs2_use = 1'b0; ex_is_load = 1'b0; ex_rd_en = 1'b0;
    ex_branch_taken = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;
    dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [AW-1:0] addr);
    ex_is_load = 1'b1; ex_rd_en = 1'b1; ex_rd_addr = addr;
    id_rs1_addr = addr; id_rs1_use = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    if (state !== 2'd0) begin $display("[TB] FAIL rst_state: got %0d expected 0", state); miscompares++; end
    vectors++;
    if (stall_cnt !== 32'd0) begin $display("[TB] FAIL rst_stall: got %0d expected 0", stall_cnt); miscompares++; end
    vectors++;
    if (flush_cnt !== 16'd0) begin $display("[TB] FAIL rst_flush: got %0d expected 0", flush_cnt); miscompares++; end
    vectors++;
    if (mem_err !== 1'b0) begin $display("[TB] FAIL rst_mem_err: got %b expected 0", mem_err); miscompares++; end
    vectors++;
    if (ctrl !== C_NONE) begin $display("[TB] FAIL rst_ctrl: got %b expected %b", ctrl, C_NONE); miscompares++; end
    vectors++;
    set_load_use(5'd7);
    #1;
    if (ctrl !== C_LOADUSE) begin $display("[TB] FAIL rst_run_decode: got %b expected %b", ctrl, C_LOADUSE); miscompares++; end
    vectors++;
    drive_idle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_load_use();
    set_load_use(5'd5);
    @(negedge clk);
    if (ctrl !== C_LOADUSE) begin $display("[TB] FAIL lu_ctrl: got %b expected %b", ctrl, C_LOADUSE); miscompares++; end
    vectors++;
    exp_stall++;
    next_cycle();
    drive_idle();
    @(negedge clk);
    if (state !== 2'd0) begin $display("[TB] FAIL lu_state: got %0d expected 0", state); miscompares++; end
    vectors++;
    if (stall_cnt !== exp_stall) begin $display("[TB] FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); miscompares++; end
    vectors++;
    if (ctrl !== C_NONE) begin $display("[TB] FAIL lu_release: got %b expected %b", ctrl, C_NONE); miscompares++; end
    vectors++;
    next_cycle();
    set_load_use(5'd0);
    @(negedge clk);
    if (ctrl !== C_NONE) begin $display("[TB] FAIL lu_rd0: got %b expected %b", ctrl, C_NONE); miscompares++; end
    vectors++;
    next_cycle();
    drive_idle();
  endtask

  task automatic test_branch();
    set_load_use(5'd5);
    ex_branch_taken = 1'b1;
    @(negedge clk);
    if (ctrl !== C_FLUSH) begin $display("[TB] FAIL br_ctrl: got %b expected %b", ctrl, C_FLUSH); miscompares++; end
    vectors++;
    if (flush_cnt !== exp_flush) begin $display("[TB] FAIL br_flush_before: got %0d expected %0d", flush_cnt, exp_flush); miscompares++; end
    vectors++;
    exp_flush++;
    next_cycle();
    drive_idle();
    @(negedge clk);
    if (flush_cnt !== exp_flush) begin $display("[TB] FAIL br_flush_after: got %0d expected %0d", flush_cnt, exp_flush); miscompares++; end
    vectors++;
    if (stall_cnt !== exp_stall) begin $display("[TB] FAIL br_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); miscompares++; end
    vectors++;
    next_cycle();
  endtask

  task automatic test_mdu();
    drive_idle();
    mdu_start = 1'b1;
    @(negedge clk);
    if (state !== 2'd0) begin $display("[TB] FAIL mdu_start_state: got %0d expected 0", state); miscompares++; end
    vectors++;
    if (ctrl !== C_MDU) begin $display("[TB] FAIL mdu_start_ctrl: got %b expected %b", ctrl, C_MDU); miscompares++; end
    vectors++;
    exp_stall++;
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      ex_branch_taken = (k == 1);
      @(negedge clk);
      if (state !== 2'd1) begin $display("[TB] FAIL mdu_wait_state[%0d]: got %0d expected 1", k, state); miscompares++; end
      vectors++;
      if (ctrl !== C_MDU) begin $display("[TB] FAIL mdu_wait_ctrl[%0d]: got %b expected %b", k, ctrl, C_MDU); miscompares++; end
      vectors++;
      exp_stall++;
      next_cycle();
    end
    ex_branch_taken = 1'b0;
    mdu_done = 1'b1;
    @(negedge clk);
    if (state !== 2'd1) begin $display("[TB] FAIL mdu_done_state: got %0d expected 1", state); miscompares++; end
    vectors++;
    if (ctrl !== C_NONE) begin $display("[TB] FAIL mdu_done_ctrl: got %b expected %b", ctrl, C_NONE); miscompares++; end
    vectors++;
    next_cycle();
    drive_idle();
    @(negedge clk);
    if (state !== 2'd0) begin $display("[TB] FAIL mdu_exit_state: got %0d expected 0", state); miscompares++; end
    vectors++;
    if (stall_cnt !== exp_stall) begin $display("[TB] FAIL mdu_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); miscompares++; end
    vectors++;
    if (flush_cnt !== exp_flush) begin $display("[TB] FAIL mdu_branch_ignored: got %0d expected %0d", flush_cnt, exp_flush); miscompares++; end
    vectors++;
    next_cycle();
  endtask

  task automatic test_mem_then_mdu();
    drive_idle();
    dmem_req = 1'b1;
    mdu_start = 1'b1;
    @(negedge clk);
    if (ctrl !== C_MEM) begin $display("[TB] FAIL mm_run_ctrl: got %b expected %b", ctrl, C_MEM); miscompares++; end
    vectors++;
    exp_stall++;
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (state !== 2'd2) begin $display("[TB] FAIL mm_wait_state[%0d]: got %0d expected 2", k, state); miscompares++; end
      vectors++;
      if (ctrl !== C_MEM) begin $display("[TB] FAIL mm_wait_ctrl[%0d]: got %b expected %b", k, ctrl, C_MEM); miscompares++; end
      vectors++;
      exp_stall++;
      next_cycle();
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    if (ctrl !== C_NONE) begin $display("[TB] FAIL mm_ack_ctrl: got %b expected %b", ctrl, C_NONE); miscompares++; end
    vectors++;
    next_cycle();
    dmem_req = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    if (state !== 2'd0) begin $display("[TB] FAIL mm_back_run: got %0d expected 0", state); miscompares++; end
    vectors++;
    if (ctrl !== C_MDU) begin $display("[TB] FAIL mm_mdu_ctrl: got %b expected %b", ctrl, C_MDU); miscompares++; end
    vectors++;
    exp_stall++;
    next_cycle();
    @(negedge clk);
    if (state !== 2'd1) begin $display("[TB] FAIL mm_mdu_state: got %0d expected 1", state); miscompares++; end
    vectors++;
    if (ctrl !== C_MDU) begin $display("[TB] FAIL mm_mdu_wait_ctrl: got %b expected %b", ctrl, C_MDU); miscompares++; end
    vectors++;
    exp_stall++;
    next_cycle();
    mdu_done = 1'b1;
    next_cycle();
    drive_idle();
    @(negedge clk);
    if (stall_cnt !== exp_stall) begin $display("[TB] FAIL mm_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); miscompares++; end
    vectors++;
    if (mem_err !== 1'b0) begin $display("[TB] FAIL mm_mem_err: got %b expected 0", mem_err); miscompares++; end
    vectors++;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive_idle();
    for (int k = 0; k < 2; k++) begin
      ex_branch_taken = 1'b1;
      @(negedge clk);
      if (ctrl !== C_FLUSH) begin $display("[TB] FAIL b2b_flush[%0d]: got %b expected %b", k, ctrl, C_FLUSH); miscompares++; end
      vectors++;
      exp_flush++;
      next_cycle();
    end
    drive_idle();
    ex_is_load = 1'b1; ex_rd_en = 1'b1; ex_rd_addr = 5'd9;
    id_rs2_addr = 5'd9; id_rs2_use = 1'b1; id_rs1_addr = 5'd9;
    @(negedge clk);
    if (ctrl !== C_LOADUSE) begin $display("[TB] FAIL b2b_rs2_lu: got %b expected %b", ctrl, C_LOADUSE); miscompares++; end
    vectors++;
    exp_stall++;
    next_cycle();
    id_rs2_use = 1'b0;
    @(negedge clk);
    if (ctrl !== C_NONE) begin $display("[TB] FAIL b2b_unused_src: got %b expected %b", ctrl, C_NONE); miscompares++; end
    vectors++;
    next_cycle();
    id_rs1_use = 1'b1; ex_rd_en = 1'b0;
    @(negedge clk);
    if (ctrl !== C_NONE) begin $display("[TB] FAIL b2b_no_rd_en: got %b expected %b", ctrl, C_NONE); miscompares++; end
    vectors++;
    next_cycle();
    drive_idle();
    @(negedge clk);
    if (flush_cnt !== exp_flush) begin $display("[TB] FAIL b2b_flush_cnt: got %0d expected %0d", flush_cnt, exp_flush); miscompares++; end
    vectors++;
    if (stall_cnt !== exp_stall) begin $display("[TB] FAIL b2b_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); miscompares++; end
    vectors++;
    next_cycle();
  endtask

  task automatic test_timeout();
    drive_idle();
    dmem_req = 1'b1;
    @(negedge clk);
    if (ctrl !== C_MEM) begin $display("[TB] FAIL to_run_ctrl: got %b expected %b", ctrl, C_MEM); miscompares++; end
    vectors++;
    exp_stall++;
    next_cycle();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (state !== 2'd2) begin $display("[TB] FAIL to_state[%0d]: got %0d expected 2", k, state); miscompares++; end
      vectors++;
      if (ctrl !== ((k < 8) ? C_MEM : C_NONE)) begin
        $display("[TB] FAIL to_ctrl[%0d]: got %b expected %b", k, ctrl, (k < 8) ? C_MEM : C_NONE); miscompares++;
      end
      vectors++;
      if (mem_err !== 1'b0) begin $display("[TB] FAIL to_err_early[%0d]: got %b expected 0", k, mem_err); miscompares++; end
      vectors++;
      if (k < 8) exp_stall++;
      next_cycle();
    end
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (state !== 2'd0) begin $display("[TB] FAIL to_after_state[%0d]: got %0d expected 0", k, state); miscompares++; end
      vectors++;
      if (mem_err !== 1'b1) begin $display("[TB] FAIL to_err_sticky[%0d]: got %b expected 1", k, mem_err); miscompares++; end
      vectors++;
      next_cycle();
    end
    @(negedge clk);
    if (stall_cnt !== exp_stall) begin $display("[TB] FAIL to_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); miscompares++; end
    vectors++;
    next_cycle();
  endtask

  task automatic test_async_reset();
    drive_idle();
    mdu_start = 1'b1;
    next_cycle();
    next_cycle();
    #2;
    if (state !== 2'd1) begin $display("[TB] FAIL ar_pre_state: got %0d expected 1", state); miscompares++; end
    vectors++;
    rst = 1'b1;
    #1;
    if (state !== 2'd0) begin $display("[TB] FAIL ar_state: got %0d expected 0", state); miscompares++; end
    vectors++;
    if (stall_cnt !== 32'd0) begin $display("[TB] FAIL ar_stall_cnt: got %0d expected 0", stall_cnt); miscompares++; end
    vectors++;
    if (flush_cnt !== 16'd0) begin $display("[TB] FAIL ar_flush_cnt: got %0d expected 0", flush_cnt); miscompares++; end
    vectors++;
    if (mem_err !== 1'b0) begin $display("[TB] FAIL ar_mem_err: got %b expected 0", mem_err); miscompares++; end
    vectors++;
    if (ctrl !== C_MDU) begin $display("[TB] FAIL ar_run_decode: got %b expected %b", ctrl, C_MDU); miscompares++; end
    vectors++;
    exp_stall = '0;
    exp_flush = '0;
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    if (state !== 2'd0) begin $display("[TB] FAIL ar_after_state: got %0d expected 0", state); miscompares++; end
    vectors++;
    if (stall_cnt !== exp_stall) begin $display("[TB] FAIL ar_after_stall: got %0d expected %0d", stall_cnt, exp_stall); miscompares++; end
    vectors++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_mem_then_mdu();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
